apb_protocol_monitor: RTL
=========================

# apb_protocol_monitor

Synthesizable, parametrised APB4 protocol monitor that passively observes one APB4 bus carrying NUM_SLAVES select lines. It tracks the transfer phase, checks handshake and signal-stability rules, enforces a PREADY wait-state timeout and counts transfers and errors. It sits beside the APB master/slave pair in both the bench and silicon builds, and extends the simulation-only property checks to multi-slave buses with timeout, sticky error reporting and counters.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA width; must be a multiple of 8
- NUM_SLAVES, 4, PSEL width (1..16)
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles allowed with PREADY low (≥1)
- CNT_WIDTH, 8, width of all counters

Ports:
- PCLK  in  1  bus clock; the only clock
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  NUM_SLAVES  observed slave selects
- PENABLE, PWRITE, PREADY, PSLVERR  in  1 each  observed bus signals
- PADDR  in  ADDR_WIDTH  observed address
- PWDATA  in  DATA_WIDTH  observed write data
- PSTRB  in  DATA_WIDTH/8  observed strobes
- PPROT  in  3  observed protection
- clr  in  1  synchronous clear of sticky flags and counters
- err_pulse  out  8  one-cycle error indication, bit-coded as below
- err_sticky  out  8  accumulated error bits
- err_count  out  CNT_WIDTH  number of cycles with any error, saturating
- xfer_count  out  CNT_WIDTH  completed transfers, saturating
- max_wait  out  CNT_WIDTH  largest wait-state count of any completed transfer
- phase  out  2  tracker state: 0 IDLE, 1 SETUP, 2 ACCESS

## Operation
- Error bits:
  - [0] MULTI_SEL: more than one PSEL bit high.
  - [1] ENABLE_NO_SETUP: PENABLE high in a cycle classified from IDLE.
  - [2] SETUP_NO_ENABLE: cycle after SETUP has PENABLE low or PSEL changed.
  - [3] UNSTABLE: in an access cycle, PADDR/PWRITE/PSTRB/PPROT differ from the captured setup values, or PWDATA differs on a write.
  - [4] SEL_DROP: PSEL changed or PENABLE fell while in ACCESS before PREADY.
  - [5] TIMEOUT: wait-state count reaches TIMEOUT_CYCLES.
  - [6] STRB_ON_READ: PSTRB ≠ 0 with PWRITE=0 at setup.
  - [7] SLVERR_STRAY: PSLVERR high outside an access cycle with PREADY=1.
- The state register holds the classification context for the next sampled cycle. All transitions are evaluated at posedge PCLK.
- IDLE:
  - PSEL≠0, PENABLE=0 → SETUP. Capture PSEL, PADDR, PWRITE, PWDATA, PSTRB, PPROT. Check bit 6.
  - PSEL≠0, PENABLE=1 → flag bit 1; stay IDLE.
  - Otherwise stay IDLE.
- SETUP:
  - PENABLE=1 and PSEL equal to the captured value → first access cycle. Run the stability check (bit 3).
    - PREADY=1: transfer completes; xfer_count+1; max_wait updated with 0; → IDLE.
    - PREADY=0: wait count := 1 → ACCESS.
  - Otherwise flag bit 2 → IDLE. That cycle is not re-classified as a new setup.
- ACCESS:
  - PSEL≠captured or PENABLE=0 → flag bit 4 → IDLE.
  - Otherwise run the stability check.
    - PREADY=1: complete; xfer_count+1; max_wait := max(max_wait, wait count) → IDLE.
    - PREADY=0 and wait count+1 = TIMEOUT_CYCLES: flag bit 5; abandon → IDLE.
    - Otherwise wait count+1.
- Bits 0 and 7 are checked every cycle, independent of state.
- err_pulse holds the bits detected at the last edge; err_sticky |= err_pulse. err_count increments by 1 per edge with any bit set, never once per bit.
- Counters saturate at 2^CNT_WIDTH−1 and never wrap. The wait counter is $clog2(TIMEOUT_CYCLES+1) wide; max_wait is zero-extended or saturated to CNT_WIDTH.
- clr=1:
  - Zeroes err_sticky, err_count, xfer_count and max_wait at the next edge.
  - An error or completion detected on that same edge takes priority: its bit is set and its counter is loaded with 1.
  - clr does not affect phase or the captured values.

## Timing
- Reset (PRESETn low, asynchronous): phase=IDLE and every output, wait counter and capture register is 0. Exit from reset takes effect at the first posedge after PRESETn rises.
- A reset during an active transfer discards it; the first post-reset cycle is classified from IDLE.
- Latency: an error in bus cycle N appears on err_pulse and err_sticky during cycle N+1. err_pulse stays high for exactly one cycle unless the error repeats.
- xfer_count and max_wait update in the cycle after the PREADY=1 access cycle.
- Back-to-back transfers: a setup cycle that immediately follows a completion is classified correctly with no idle cycle required.
- With TIMEOUT_CYCLES=T, the error fires on the edge sampling the T-th consecutive PREADY=0 access cycle.

## Test plan
- Reset mid-transfer: drop PRESETn during ACCESS → all outputs 0 immediately; phase=0; xfer_count=0 after release.
- Clean write, 0 waits, followed back-to-back by a read with 3 waits → xfer_count=2, max_wait=3, err_sticky=0x00.
- PADDR changes from 0x10 to 0x14 during the second access cycle → err_pulse=0x08 for one cycle; err_count=1.
- TIMEOUT_CYCLES=4, PREADY held low → err_pulse bit 5 set after the 4th wait cycle; phase=IDLE; xfer_count unchanged.
- PSEL=4'b0011 with PENABLE=1 from IDLE → err_pulse=0x03; err_count=1, not 2.
- clr asserted on the same edge as a SEL_DROP → err_sticky=0x10, err_count=1, xfer_count=0.

Source files
------------

// File: rtl/apb_protocol_monitor.sv
`default_nettype none
// ============================================================================
// Module      : apb_protocol_monitor
// Description : Passive APB4 protocol monitor. It classifies every bus cycle
//               as IDLE, SETUP or ACCESS and checks handshake and signal
//               stability. It also enforces a PREADY wait-state timeout and
//               keeps sticky error flags plus saturating transfer, error and
//               max-wait counters.
// Ports       : PCLK, PRESETn (async, active-low)
//               PSEL[NUM_SLAVES], PENABLE, PWRITE, PREADY, PSLVERR, PADDR,
//               PWDATA, PSTRB, PPROT  - observed bus (inputs only)
//               clr        - synchronous clear of sticky flags and counters
//               err_pulse  - errors detected at the last edge (one cycle)
//               err_sticky - accumulated error bits
//               err_count  - cycles with any error (saturating)
//               xfer_count - completed transfers (saturating)
//               max_wait   - largest wait-state count of completed transfers
//               phase      - tracker state: 0 IDLE, 1 SETUP, 2 ACCESS
// Revision    : 1.0 - initial release
// ============================================================================
module apb_protocol_monitor #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [NUM_SLAVES-1:0]   PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic                    clr,
    output logic [7:0]              err_pulse,
    output logic [7:0]              err_sticky,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    xfer_count,
    output logic [CNT_WIDTH-1:0]    max_wait,
    output logic [1:0]              phase
);

    localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_STRB_W = DATA_WIDTH / 8;
    localparam int c_EXT_W  = (c_WAIT_W > CNT_WIDTH) ? c_WAIT_W : CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX = '1;
    localparam logic [NUM_SLAVES-1:0] c_SEL_ONE = NUM_SLAVES'(1);
    // Wait count held while in ACCESS when the next PREADY=0 cycle is the
    // TIMEOUT_CYCLES-th one.
    localparam logic [c_WAIT_W-1:0]   c_TO_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_STRB_W-1:0]     r_strb;
    logic [2:0]              r_prot;
    logic [c_WAIT_W-1:0]     r_wait;

    state_t                  w_state_nxt;
    logic                    w_capture;
    logic [c_WAIT_W-1:0]     w_wait_nxt;
    logic [7:0]              w_err;
    logic                    w_done;
    logic [c_WAIT_W-1:0]     w_done_wait;
    logic                    w_access;
    logic                    w_unstable;
    logic [c_EXT_W-1:0]      w_done_ext;
    logic [CNT_WIDTH-1:0]    w_done_cnt;

    // A cycle qualifies as an access cycle only when the captured select is
    // still presented together with PENABLE.
    assign w_access   = PENABLE && (PSEL == r_sel);
    assign w_unstable = (PADDR != r_addr) || (PWRITE != r_write) ||
                        (PSTRB != r_strb) || (PPROT != r_prot) ||
                        (r_write && (PWDATA != r_wdata));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wait_nxt  = '0;
        w_err       = '0;
        w_done      = 1'b0;
        w_done_wait = '0;

        // x & (x-1) is non-zero exactly when two or more bits are set.
        w_err[0] = |(PSEL & (PSEL - c_SEL_ONE));
        // PSLVERR is only legal on the completing (PREADY=1) access cycle.
        w_err[7] = PSLVERR && !((r_state != S_IDLE) && w_access && PREADY);

        case (r_state)
            S_IDLE: begin
                if (PSEL != '0) begin
                    if (!PENABLE) begin
                        w_state_nxt = S_SETUP;
                        w_capture   = 1'b1;
                        w_err[6]    = !PWRITE && (PSTRB != '0);
                    end else begin
                        w_err[1] = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (w_access) begin
                    w_err[3] = w_unstable;
                    if (PREADY) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (TIMEOUT_CYCLES == 1) begin
                        w_err[5]    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wait_nxt  = c_WAIT_W'(1);
                        w_state_nxt = S_ACCESS;
                    end
                end else begin
                    // Broken handshake; the cycle is consumed, not re-used
                    // as a fresh setup.
                    w_err[2]    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (!w_access) begin
                    w_err[4]    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err[3] = w_unstable;
                    if (PREADY) begin
                        w_done      = 1'b1;
                        w_done_wait = r_wait;
                        w_state_nxt = S_IDLE;
                    end else if (r_wait == c_TO_LAST) begin
                        w_err[5]    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_wait_nxt = r_wait + c_WAIT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Fit the wait count into CNT_WIDTH, saturating if it is wider.
        w_done_ext = c_EXT_W'(w_done_wait);
        w_done_cnt = (w_done_ext > c_EXT_W'(c_CNT_MAX)) ? c_CNT_MAX
                                                        : CNT_WIDTH'(w_done_ext);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_strb     <= '0;
            r_prot     <= '0;
            r_wait     <= '0;
            err_pulse  <= '0;
            err_sticky <= '0;
            err_count  <= '0;
            xfer_count <= '0;
            max_wait   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            err_pulse <= w_err;
            if (w_capture) begin
                r_sel   <= PSEL;
                r_addr  <= PADDR;
                r_write <= PWRITE;
                r_wdata <= PWDATA;
                r_strb  <= PSTRB;
                r_prot  <= PPROT;
            end

            // clr zeroes the accumulators, but an event on the same edge wins.
            err_sticky <= clr ? w_err : (err_sticky | w_err);

            if (w_err != '0)
                err_count <= clr ? CNT_WIDTH'(1)
                           : (err_count == c_CNT_MAX) ? err_count
                           : err_count + CNT_WIDTH'(1);
            else if (clr)
                err_count <= '0;

            if (w_done) begin
                xfer_count <= clr ? CNT_WIDTH'(1)
                            : (xfer_count == c_CNT_MAX) ? xfer_count
                            : xfer_count + CNT_WIDTH'(1);
                max_wait   <= (clr || (w_done_cnt > max_wait)) ? w_done_cnt
                                                               : max_wait;
            end else if (clr) begin
                xfer_count <= '0;
                max_wait   <= '0;
            end
        end
    end

    assign phase = r_state;

endmodule
`default_nettype wire
